cfg_write_arbiter: RTL and testbench

- Sole write master for the PWM configuration register bank (addresses 0x00–0x04: out-enable low/high, PWM-enable low/high, duty cycle).
- After reset, runs an init sequence that loads defaults into every register.
- Then shares the single bank write port between NUM_REQ requesters (SPI frame decoder, on-chip test sequencer, …) using round-robin arbitration and a valid/ready handshake.

---
 rtl/cfg_write_arbiter.sv | 152 +++++++++++++++
 tb/tb_cfg_write_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_write_arbiter.sv
// Sole write master for the PWM configuration register bank.
// Loads defaults after reset, then round-robin arbitrates requester writes.
module cfg_write_arbiter #(
    parameter int unsigned       NUM_REQ   = 2,
    parameter int unsigned       ADDR_W    = 7,
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       NUM_REGS  = 5,
    parameter logic [DATA_W-1:0] INIT_DUTY = DATA_W'(8'h80)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [DATA_W-1:0]           wr_data,
    output logic [1:0]                  wr_src,
    output logic                        init_done,
    output logic                        addr_err
);

    localparam int unsigned CNT_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned PTR_W     = 2;
    localparam int unsigned DUTY_ADDR = 4;

    typedef enum logic {
        ST_INIT,
        ST_ARB
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;

    logic                 wr_en_d, addr_err_d, init_done_d;
    logic [ADDR_W-1:0]    wr_addr_d;
    logic [DATA_W-1:0]    wr_data_d;
    logic [1:0]           wr_src_d;

    logic [PTR_W-1:0]           grant;
    logic                       found;
    logic [NUM_REQ-1:0]         vshift;
    int                         idx;
    logic [NUM_REQ*ADDR_W-1:0]  addr_sh;
    logic [NUM_REQ*DATA_W-1:0]  data_sh;
    logic [ADDR_W-1:0]          win_addr;
    logic [DATA_W-1:0]          win_data;

    // Round-robin search: first valid requester starting at the pointer.
    always_comb begin
        grant  = '0;
        found  = 1'b0;
        vshift = '0;
        idx    = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(NUM_REQ)) begin
                idx = idx - int'(NUM_REQ);
            end
            vshift = req_valid >> idx;
            if (!found && vshift[0]) begin
                found = 1'b1;
                grant = PTR_W'(idx);
            end
        end
    end

    // Select the winning requester's address and data.
    always_comb begin
        addr_sh  = req_addr >> (int'(grant) * int'(ADDR_W));
        data_sh  = req_data >> (int'(grant) * int'(DATA_W));
        win_addr = addr_sh[ADDR_W-1:0];
        win_data = data_sh[DATA_W-1:0];
    end

    // Next-state, ready and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        wr_en_d     = 1'b0;
        addr_err_d  = 1'b0;
        wr_addr_d   = wr_addr;
        wr_data_d   = wr_data;
        wr_src_d    = wr_src;
        init_done_d = init_done;
        req_ready   = '0;

        case (state_q)
            ST_INIT: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ADDR_W'(cnt_q);
                wr_data_d = (cnt_q == CNT_W'(DUTY_ADDR)) ? INIT_DUTY : '0;
                wr_src_d  = 2'd0;
                if (cnt_q == CNT_W'(NUM_REGS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_ARB;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ARB: begin
                init_done_d = 1'b1;
                if (found) begin
                    // Ready goes only to a valid requester, so this is a handshake.
                    req_ready  = NUM_REQ'(1) << grant;
                    wr_addr_d  = win_addr;
                    wr_data_d  = win_data;
                    wr_src_d   = 2'(grant);
                    if (win_addr < ADDR_W'(NUM_REGS)) begin
                        wr_en_d = 1'b1;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                    ptr_d = (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + PTR_W'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters and registered bank-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            ptr_q     <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_src    <= 2'd0;
            init_done <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            wr_en     <= wr_en_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
            wr_src    <= wr_src_d;
            init_done <= init_done_d;
            addr_err  <= addr_err_d;
        end
    end

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Randomized self-checking bench for cfg_write_arbiter against a cycle-level reference model.
module tb_cfg_write_arbiter;

    localparam int N  = 2;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int NR = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [1:0]        wr_src;
    logic              init_done;
    logic              addr_err;

    cfg_write_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_src    (wr_src),
        .init_done (init_done),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Requester-side stimulus: held until accepted.
    logic          v [N];
    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];

    // Reference model: init progress, pointer and expected outputs.
    // Output vector layout: {wr_en, wr_addr, wr_data, wr_src, init_done, addr_err}.
    int          m_init_idx;
    bit          m_arb;
    int          m_ptr;
    int          m_grant;
    logic [19:0] m_out;
    logic [N-1:0] exp_ready;

    function automatic logic [19:0] outs();
        return {wr_en, wr_addr, wr_data, wr_src, init_done, addr_err};
    endfunction

    task automatic model_reset();
        m_init_idx = 0;
        m_arb      = 0;
        m_ptr      = 0;
        m_grant    = -1;
        m_out      = '0;
    endtask

    // Drive the current stimulus and compute what this cycle should produce.
    task automatic predict();
        bit ok;
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = v[i];
            req_addr[i*AW +: AW]  = a[i];
            req_data[i*DW +: DW]  = d[i];
        end
        #1;
        exp_ready = '0;
        m_grant   = -1;
        if (!m_arb) begin
            m_out = {1'b1, AW'(m_init_idx), (m_init_idx == 4) ? 8'h80 : 8'h00, 2'd0, 1'b0, 1'b0};
            m_init_idx++;
            if (m_init_idx == NR) m_arb = 1;
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (m_grant < 0 && v[j]) m_grant = j;
            end
            if (m_grant >= 0) begin
                exp_ready[m_grant] = 1'b1;
                ok = (int'(a[m_grant]) < NR);
                m_out = {ok, a[m_grant], d[m_grant], 2'(m_grant), 1'b1, !ok};
                m_ptr = (m_grant + 1) % N;
            end else begin
                m_out = {1'b0, m_out[18:2], 1'b1, 1'b0};
            end
        end
    endtask

    task automatic retire();
        if (m_grant >= 0) v[m_grant] = 1'b0;
    endtask

    // Hold reset for a few cycles and release it between clock edges.
    task automatic apply_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0; a[i] = '0; d[i] = '0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1; a[i] = AW'(i); d[i] = 8'hFF;
        end
        predict();
        model_reset();
        @(posedge clk); #1;
        n_cmp++;
        if (outs() !== 20'h0 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got outs=%h ready=%b want outs=00000 ready=0", outs(), req_ready);
        end
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            predict();
            n_cmp++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL init_ready c%0d: got %b want %b", c, req_ready, exp_ready);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (outs() !== m_out) begin
                n_fail++;
                $display("FAIL init_out c%0d: got %h want %h", c, outs(), m_out);
            end
            retire();
        end
    endtask

    task automatic test_single();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) begin v[0] = 1'b1; a[0] = 7'h01; d[0] = 8'hA5; end
            predict();
            n_cmp++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL single_ready c%0d: got %b want %b", c, req_ready, exp_ready);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (outs() !== m_out) begin
                n_fail++;
                $display("FAIL single_out c%0d: got %h want %h", c, outs(), m_out);
            end
            retire();
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 4) begin
                v[0] = 1'b1; a[0] = 7'h02; d[0] = 8'h11;
                v[1] = 1'b1; a[1] = 7'h03; d[1] = 8'h22;
            end
            predict();
            n_cmp++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL b2b_ready c%0d: got %b want %b", c, req_ready, exp_ready);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (outs() !== m_out) begin
                n_fail++;
                $display("FAIL b2b_out c%0d: got %h want %h", c, outs(), m_out);
            end
            retire();
        end
        // Drain whatever is still pending.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            predict();
            @(posedge clk); #1;
            n_cmp++;
            if (outs() !== m_out) begin
                n_fail++;
                $display("FAIL b2b_drain c%0d: got %h want %h", c, outs(), m_out);
            end
            retire();
        end
    endtask

    task automatic test_addr_err();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin v[1] = 1'b1; a[1] = 7'h05; d[1] = 8'h33; end
            if (c == 2) begin v[1] = 1'b1; a[1] = 7'h44; d[1] = 8'h44; end
            predict();
            n_cmp++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL err_ready c%0d: got %b want %b", c, req_ready, exp_ready);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (outs() !== m_out) begin
                n_fail++;
                $display("FAIL err_out c%0d: got %h want %h", c, outs(), m_out);
            end
            retire();
        end
    endtask

    task automatic test_init_pending();
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 2) begin v[0] = 1'b1; a[0] = 7'h04; d[0] = 8'h10; end
            predict();
            n_cmp++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL initpend_ready c%0d: got %b want %b", c, req_ready, exp_ready);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (outs() !== m_out) begin
                n_fail++;
                $display("FAIL initpend_out c%0d: got %h want %h", c, outs(), m_out);
            end
            retire();
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!v[i]) begin
                    v[i] = 1'b1; a[i] = AW'($urandom_range(0, 4)); d[i] = DW'($urandom);
                end
            end
            predict();
            @(posedge clk); #1;
            n_cmp++;
            if (outs() !== m_out) begin
                n_fail++;
                $display("FAIL midrst_stream c%0d: got %h want %h", c, outs(), m_out);
            end
            retire();
        end
        @(negedge clk);
        predict();
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (outs() !== 20'h0 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL midrst_async: got outs=%h ready=%b want outs=00000 ready=0", outs(), req_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (outs() !== 20'h0) begin
            n_fail++;
            $display("FAIL midrst_nowrite: got %h want 00000", outs());
        end
        #1 rst = 1'b0;
        model_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            predict();
            n_cmp++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL midrst_ready c%0d: got %b want %b", c, req_ready, exp_ready);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (outs() !== m_out) begin
                n_fail++;
                $display("FAIL midrst_out c%0d: got %h want %h", c, outs(), m_out);
            end
            retire();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 9) < 6) begin
                    v[i] = 1'b1;
                    a[i] = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 4));
                    d[i] = DW'($urandom);
                end
            end
            predict();
            n_cmp++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rand_ready c%0d: got %b want %b", c, req_ready, exp_ready);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (outs() !== m_out) begin
                n_fail++;
                $display("FAIL rand_out c%0d: got %h want %h", c, outs(), m_out);
            end
            retire();
        end
    endtask

    initial begin
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_addr_err();
        test_init_pending();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
